// File: rtl/bayer_pkg.sv
// Shared types for the Bayer row-tap front end: pixel type, FSM states, counter sizing.
package bayer_pkg;

  localparam int unsigned PIX_W = 12;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } row_tap_state_e;

  // Counter width for a given depth; never below one bit.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/row_tap_ram.sv
// One-line pixel store: 1R1W, synchronous read-before-write at the same address.
module row_tap_ram
  import bayer_pkg::*;
#(
  parameter int unsigned DATA_W = PIX_W,
  parameter int unsigned LINE_W = 640,
  parameter int unsigned ADDR_W = cnt_w(LINE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [LINE_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Output register resets and holds between accesses so the tap is stable during stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bayer_row_tap.sv
// Line-buffer front end presenting current-row and previous-row taps for 2x2 Bayer quads.
// Optional sticky frame_err output is enabled by defining ROW_TAP_ERR_EN.
module bayer_row_tap
  import bayer_pkg::*;
#(
  parameter int unsigned DATA_W = PIX_W,
  parameter int unsigned LINE_W = 640,
  parameter int unsigned ROWS   = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] tap0,
  output logic [DATA_W-1:0] tap1,
  output logic              out_valid,
  output logic              quad_valid,
`ifdef ROW_TAP_ERR_EN
  output logic              frame_err,
`endif
  output logic              frame_done
);

  localparam int unsigned COL_W = cnt_w(LINE_W);
  localparam int unsigned ROW_W = cnt_w(ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  row_tap_state_e    state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] tap0_q, tap0_d;
  logic              out_valid_q, out_valid_d;
  logic              quad_valid_q, quad_valid_d;
  logic              frame_done_q, frame_done_d;

  logic              accept;
  logic [COL_W-1:0]  pos_col;
  logic [ROW_W-1:0]  pos_row;
  logic              col_wrap;
  logic              last_pix;

  always_comb begin
    accept   = pix_valid && (sof || (state_q != IDLE));
    // A sof pixel is always (0,0), regardless of where the counters were.
    pos_col  = sof ? '0 : col_q;
    pos_row  = sof ? '0 : row_q;
    col_wrap = (pos_col == COL_LAST);
    last_pix = col_wrap && (pos_row == ROW_LAST);

    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    tap0_d       = tap0_q;
    out_valid_d  = 1'b0;
    quad_valid_d = 1'b0;
    frame_done_d = 1'b0;

    if (accept) begin
      tap0_d       = pix_in;
      out_valid_d  = (pos_row != '0);
      quad_valid_d = pos_row[0] && pos_col[0];
      frame_done_d = last_pix;

      if (col_wrap) begin
        col_d = '0;
        row_d = last_pix ? '0 : pos_row + ROW_W'(1);
      end else begin
        col_d = pos_col + COL_W'(1);
        row_d = pos_row;
      end

      if (last_pix) begin
        state_d = IDLE;
      end else if (col_wrap && (pos_row == '0)) begin
        state_d = STREAM;
      end else if (sof) begin
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      tap0_q       <= '0;
      out_valid_q  <= 1'b0;
      quad_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      tap0_q       <= tap0_d;
      out_valid_q  <= out_valid_d;
      quad_valid_q <= quad_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  row_tap_ram #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W),
    .ADDR_W (COL_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .addr  (pos_col),
    .wdata (pix_in),
    .rdata (tap1)
  );

`ifdef ROW_TAP_ERR_EN
  logic frame_err_q, frame_err_d;

  // In IDLE a sof clears the flag and a bare pixel sets it; mid-frame sof sets it.
  always_comb begin
    frame_err_d = frame_err_q;
    if (pix_valid) begin
      if (state_q == IDLE) begin
        frame_err_d = !sof;
      end else if (sof) begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`endif

  assign tap0       = tap0_q;
  assign out_valid  = out_valid_q;
  assign quad_valid = quad_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bayer_row_tap.sv
// Scoreboard bench for bayer_row_tap with a 4x4 frame: directed frames, stalls, resync, reset.
module tb_bayer_row_tap;
  import bayer_pkg::*;

  localparam int unsigned LW = 4;
  localparam int unsigned RW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pix_t pix_in;
  logic pix_valid;
  logic sof;
  pix_t tap0;
  pix_t tap1;
  logic out_valid;
  logic quad_valid;
  logic frame_done;
`ifdef ROW_TAP_ERR_EN
  logic frame_err;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int cyc;
    int tap0;
    int tap1;
    bit quad;
    bit done;
  } exp_t;

  exp_t exp_q[$];

  bayer_row_tap #(
    .DATA_W (PIX_W),
    .LINE_W (LW),
    .ROWS   (RW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .tap0       (tap0),
    .tap1       (tap1),
    .out_valid  (out_valid),
    .quad_valid (quad_valid),
`ifdef ROW_TAP_ERR_EN
    .frame_err  (frame_err),
`endif
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each call occupies one cycle; the expected output is due one cycle after capture.
  task automatic drive(input bit v, input bit s, input int pix, input bit exp_out,
                       input int exp_t1, input bit q, input bit d);
    exp_t e;
    @(posedge clk);
    #1;
    pix_valid = v;
    sof       = s;
    pix_in    = pix_t'(pix);
    if (exp_out) begin
      e = '{cyc, pix, exp_t1, q, d};
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Pixel i of a frame carries value base+i; the row above holds base+i-LW.
  task automatic run_frame(input int base, input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      if (stall && i > 0) idle();
      drive(1'b1, i == 0, base + i, i >= int'(LW), base + i - int'(LW),
            ((i / int'(LW)) % 2 == 1) && ((i % int'(LW)) % 2 == 1), i == int'(LW * RW) - 1);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    @(posedge clk);
    #1;
    check("rst_tap0", 32'(tap0), 0);
    check("rst_tap1", 32'(tap1), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_quad_valid", 32'(quad_valid), 0);
    check("rst_frame_done", 32'(frame_done), 0);
`ifdef ROW_TAP_ERR_EN
    check("rst_frame_err", 32'(frame_err), 0);
`endif
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid actual=1 required=0 (cycle %0d) tap0=%0d", cyc, tap0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("latency", 32'(cyc), 32'(e.cyc + 1));
          check("tap0", 32'(tap0), 32'(e.tap0));
          check("tap1", 32'(tap1), 32'(e.tap1));
          check("quad_valid", 32'(quad_valid), 32'(e.quad));
          check("frame_done", 32'(frame_done), 32'(e.done));
        end
      end else begin
        check("out_valid_known", 32'(out_valid), 0);
        check("quad_when_idle", 32'(quad_valid), 0);
        check("done_when_idle", 32'(frame_done), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pix_valid = 1'b0;
    sof       = 1'b0;
    pix_in    = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("init_tap0", 32'(tap0), 0);
    check("init_tap1", 32'(tap1), 0);
    check("init_out_valid", 32'(out_valid), 0);
    check("init_quad_valid", 32'(quad_valid), 0);
    check("init_frame_done", 32'(frame_done), 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Continuous frame, then the same frame with alternate-cycle stalls.
    run_frame(0, 16, 1'b0);
    idle();
    run_frame(0, 16, 1'b1);
    idle();

    // Back-to-back frames: second frame's row 1 must see its own row 0.
    run_frame(20, 16, 1'b0);
    run_frame(40, 16, 1'b0);
    idle();

    // Mid-frame sof at pixel 6 restarts at (0,0).
    run_frame(60, 6, 1'b0);
    run_frame(100, 16, 1'b0);
    idle();
`ifdef ROW_TAP_ERR_EN
    check("resync_frame_err", 32'(frame_err), 1);
`endif

    // Reset at pixel 9, then a clean frame.
    run_frame(150, 9, 1'b0);
    do_reset();
    run_frame(0, 16, 1'b0);
    idle();

    // Bare pixels in IDLE after reset are dropped.
    do_reset();
    repeat (5) drive(1'b1, 1'b0, 77, 1'b0, 0, 1'b0, 1'b0);
    idle();
    idle();
    check("drop_tap0", 32'(tap0), 0);
    check("drop_tap1", 32'(tap1), 0);
`ifdef ROW_TAP_ERR_EN
    check("drop_frame_err", 32'(frame_err), 1);
`endif
    run_frame(0, 16, 1'b0);
    idle();
`ifdef ROW_TAP_ERR_EN
    check("sof_clears_frame_err", 32'(frame_err), 0);
`endif

    repeat (4) idle();
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
